// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared constants, fetch-state encoding and helpers for the IF stage
package if_fetch_pkg;

    localparam logic RstEnable = 1'b1;
    localparam logic ENABLE    = 1'b1;
    localparam logic DISABLE   = 1'b0;

    localparam int InsAddrWidth = 32;
    localparam int InsWidth     = 32;

    localparam logic [InsAddrWidth-1:0] ZeroWord = '0;

    typedef enum logic [1:0] {
        FetchReset = 2'b00,
        FetchReq   = 2'b01,
        FetchValid = 2'b10
    } fetch_state_t;

    // ID can only steer the PC while ID itself is not frozen.
    function automatic logic redirect_accepted(input logic branch_flag, input logic [5:0] stall);
        return branch_flag & ~stall[2];
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter, pending-redirect flag/target and next-PC selection
module fetch_pc_reg
    import if_fetch_pkg::*;
#(
    parameter logic [InsAddrWidth-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [InsAddrWidth-1:0] PC_STEP  = 32'd4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_fetch,
    input  logic                    in_valid,
    input  logic                    mem_ack,
    input  logic                    consume,
    input  logic                    redirect,
    input  logic [InsAddrWidth-1:0] redirect_target,
    output logic [InsAddrWidth-1:0] pc,
    output logic                    redir_pend
);

    logic [InsAddrWidth-1:0] redir_pc;
    logic [InsAddrWidth-1:0] pc_nxt;
    logic [InsAddrWidth-1:0] redir_pc_nxt;
    logic                    redir_pend_nxt;

    always_comb begin
        pc_nxt         = pc;
        redir_pend_nxt = redir_pend;
        redir_pc_nxt   = redir_pc;
        if (in_valid) begin
            if (redirect) begin
                pc_nxt = redirect_target;
            end else if (consume) begin
                pc_nxt = pc + PC_STEP;
            end
        end else if (in_fetch) begin
            if (mem_ack) begin
                // The outstanding access completes; any redirect now takes effect.
                redir_pend_nxt = DISABLE;
                if (redirect) begin
                    pc_nxt = redirect_target;
                end else if (redir_pend) begin
                    pc_nxt = redir_pc;
                end
            end else if (redirect) begin
                // Address must stay stable until ack, so park the target.
                redir_pend_nxt = ENABLE;
                redir_pc_nxt   = redirect_target;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            pc         <= RESET_PC;
            redir_pend <= DISABLE;
            redir_pc   <= ZeroWord;
        end else begin
            pc         <= pc_nxt;
            redir_pend <= redir_pend_nxt;
            redir_pc   <= redir_pc_nxt;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch front end: imem req/ack handshake and IF/ID presentation
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [InsAddrWidth-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [InsAddrWidth-1:0] PC_STEP  = 32'd4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall,
    input  logic                    branch_flag,
    input  logic [InsAddrWidth-1:0] branch_target,
    output logic                    imem_req,
    output logic [InsAddrWidth-1:0] imem_addr,
    input  logic                    imem_ack,
    input  logic [InsWidth-1:0]     imem_rdata,
    output logic [InsAddrWidth-1:0] if_pc,
    output logic [InsWidth-1:0]     if_ins,
    output logic                    stallreq_if
);

    fetch_state_t            state;
    fetch_state_t            state_nxt;
    logic [InsAddrWidth-1:0] pc;
    logic                    redir_pend;
    logic                    redirect;
    logic                    in_fetch;
    logic                    in_valid;
    logic                    capture;
    logic [InsAddrWidth-1:0] buf_pc;
    logic [InsWidth-1:0]     buf_ins;
    logic                    unused_stall;

    assign unused_stall = ^{stall[5:3], stall[0]};

    assign redirect = redirect_accepted(branch_flag, stall);
    assign in_fetch = (state == FetchReq);
    assign in_valid = (state == FetchValid);
    // Data is kept only if no redirect (pending or arriving now) invalidates it.
    assign capture  = in_fetch & imem_ack & ~redir_pend & ~redirect;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .clk             (clk),
        .rst             (rst),
        .in_fetch        (in_fetch),
        .in_valid        (in_valid),
        .mem_ack         (imem_ack),
        .consume         (~stall[1]),
        .redirect        (redirect),
        .redirect_target (branch_target),
        .pc              (pc),
        .redir_pend      (redir_pend)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state <= FetchReset;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FetchReset: state_nxt = FetchReq;
            FetchReq:   if (capture) state_nxt = FetchValid;
            FetchValid: if (redirect || !stall[1]) state_nxt = FetchReq;
            default:    state_nxt = FetchReset;
        endcase
    end

    always_comb begin
        imem_req    = DISABLE;
        imem_addr   = ZeroWord;
        if_pc       = ZeroWord;
        if_ins      = '0;
        stallreq_if = ENABLE;
        case (state)
            FetchReq: begin
                imem_req  = ENABLE;
                imem_addr = pc;
            end
            FetchValid: begin
                if_pc       = buf_pc;
                if_ins      = buf_ins;
                stallreq_if = DISABLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            buf_pc  <= ZeroWord;
            buf_ins <= '0;
        end else if (capture) begin
            buf_pc  <= pc;
            buf_ins <= imem_rdata;
        end
    end

endmodule
